// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC sample scheduler.
package dac_sched_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2
    } sched_state_t;

    localparam logic [1:0]  MODE_A    = 2'd0;
    localparam logic [1:0]  MODE_B    = 2'd1;
    localparam logic [1:0]  MODE_ALT  = 2'd2;
    localparam logic [1:0]  MODE_MUTE = 2'd3;

    localparam logic [15:0] MIDSCALE  = 16'h8000;
    localparam int          MIN_GUARD = 210;

endpackage

// File: rtl/dac_sample_scheduler_slot.sv
// One-entry valid/ready holding register; the scheduler empties it through consume.
module sample_slot
    import dac_sched_pkg::*;
(
    input  logic        clk_25mhz,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        consume,
    output logic        ready,
    output logic        full,
    output logic [15:0] data
);

    assign ready = !full && !reset;

    // Consume and load never collide: loading needs an empty slot, consuming a full one.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            data <= MIDSCALE;
        end else if (consume && full) begin
            full <= 1'b0;
        end else if (in_valid && ready) begin
            full <= 1'b1;
            data <= in_data;
        end
    end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Paces audio samples from two sources into dac_driver at a fixed rate,
// leaving a guard window after every issue for the serial transfer.
module dac_sample_scheduler
    import dac_sched_pkg::*;
#(
    parameter int SAMPLE_DIV   = 520,
    parameter int GUARD_CYCLES = 224
) (
    input  logic        clk_25mhz,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic        clear_flags,
    input  logic        a_valid,
    input  logic [15:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [15:0] b_data,
    output logic        b_ready,
    output logic        dac_data_ready,
    output logic [15:0] dac_sample,
    output logic        dac_src,
    output logic        underrun,
    output logic        overrun
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int GW = $clog2(GUARD_CYCLES);

    if (SAMPLE_DIV < GUARD_CYCLES + 2 || GUARD_CYCLES < MIN_GUARD) begin : g_param_check
        $error("dac_sample_scheduler: need SAMPLE_DIV >= GUARD_CYCLES + 2 and GUARD_CYCLES >= MIN_GUARD");
    end

    logic [CW-1:0] tick_count;
    logic          tick;
    logic          issue;
    sched_state_t  state;
    logic [GW-1:0] guard_count;
    logic [15:0]   last_sample;
    logic          alt_ptr;
    logic          enable_d;

    logic          a_full, b_full;
    logic [15:0]   a_slot, b_slot;
    logic          a_consume, b_consume;
    logic          sel_b, sel_full;
    logic [15:0]   sel_data;

    sample_slot u_slot_a (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .in_valid  (a_valid),
        .in_data   (a_data),
        .consume   (a_consume),
        .ready     (a_ready),
        .full      (a_full),
        .data      (a_slot)
    );

    sample_slot u_slot_b (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .in_valid  (b_valid),
        .in_data   (b_data),
        .consume   (b_consume),
        .ready     (b_ready),
        .full      (b_full),
        .data      (b_slot)
    );

    assign tick  = enable && (tick_count == CW'(SAMPLE_DIV - 1));
    assign issue = tick && (state == ST_WAIT);

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            tick_count <= '0;
        end else if (!enable || tick) begin
            tick_count <= '0;
        end else begin
            tick_count <= tick_count + 1'b1;
        end
    end

    // Slot selection looks only at registered slot state, so a sample landing
    // on the tick edge waits for the following tick.
    always_comb begin
        sel_b = 1'b0;
        case (mode)
            MODE_B:   sel_b = 1'b1;
            MODE_ALT: sel_b = alt_ptr;
            default:  sel_b = 1'b0;
        endcase
        sel_full  = sel_b ? b_full : a_full;
        sel_data  = sel_b ? b_slot : a_slot;
        a_consume = issue && ((mode == MODE_MUTE) || !sel_b);
        b_consume = issue && ((mode == MODE_MUTE) || sel_b);
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state          <= ST_WAIT;
            guard_count    <= '0;
            dac_data_ready <= 1'b0;
            dac_sample     <= MIDSCALE;
            dac_src        <= 1'b0;
            last_sample    <= MIDSCALE;
            alt_ptr        <= 1'b0;
            enable_d       <= 1'b0;
            underrun       <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            enable_d       <= enable;
            dac_data_ready <= 1'b0;
            if (enable && !enable_d) begin
                alt_ptr <= 1'b0;
            end

            case (state)
                ST_WAIT: begin
                    if (tick) begin
                        state          <= ST_ISSUE;
                        dac_data_ready <= 1'b1;
                        if (mode == MODE_MUTE) begin
                            dac_sample <= MIDSCALE;
                        end else begin
                            dac_src <= sel_b;
                            if (sel_full) begin
                                dac_sample  <= sel_data;
                                last_sample <= sel_data;
                            end else begin
                                dac_sample <= last_sample;
                            end
                        end
                        if (mode == MODE_ALT) begin
                            alt_ptr <= ~alt_ptr;
                        end
                    end
                end
                ST_ISSUE: begin
                    state       <= ST_GUARD;
                    guard_count <= '0;
                end
                ST_GUARD: begin
                    // Runs to completion regardless of enable so a transfer is never cut short.
                    if (guard_count == GW'(GUARD_CYCLES - 1)) begin
                        state <= ST_WAIT;
                    end else begin
                        guard_count <= guard_count + 1'b1;
                    end
                end
                default: state <= ST_WAIT;
            endcase

            if (issue && (mode != MODE_MUTE) && !sel_full) begin
                underrun <= 1'b1;
            end else if (clear_flags) begin
                underrun <= 1'b0;
            end

            if (tick && (state != ST_WAIT)) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Scoreboard bench: stimulus pushes expected issues from a slot/queue model, a monitor checks each pulse.
module tb_dac_sample_scheduler;

    localparam int DIV   = 300;
    localparam int GUARD = 224;
    localparam int CW    = $clog2(DIV);

    logic        clk_25mhz = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        clear_flags = 1'b0;
    logic        a_valid = 1'b0;
    logic [15:0] a_data = 16'h0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [15:0] b_data = 16'h0;
    logic        b_ready;
    logic        dac_data_ready;
    logic [15:0] dac_sample;
    logic        dac_src;
    logic        underrun;
    logic        overrun;

    dac_sample_scheduler #(.SAMPLE_DIV(DIV), .GUARD_CYCLES(GUARD)) dut (
        .clk_25mhz      (clk_25mhz),
        .reset          (reset),
        .enable         (enable),
        .mode           (mode),
        .clear_flags    (clear_flags),
        .a_valid        (a_valid),
        .a_data         (a_data),
        .a_ready        (a_ready),
        .b_valid        (b_valid),
        .b_data         (b_data),
        .b_ready        (b_ready),
        .dac_data_ready (dac_data_ready),
        .dac_sample     (dac_sample),
        .dac_src        (dac_src),
        .underrun       (underrun),
        .overrun        (overrun)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    int cyc = 0;
    always @(posedge clk_25mhz) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] sample;
        logic        src;
        logic        under;
        logic        ar;
        logic        br;
        int          at;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    logic        m_a_full, m_b_full, m_ptr, m_src, m_under;
    logic [15:0] m_a, m_b, m_last;
    int          en_cyc, tick_k, last_pulse;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_25mhz) begin
        if (!reset && dac_data_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_pulse", {31'd0, dac_data_ready}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("pulse_cycle", cyc, e.at);
                checkOutput("pulse_sample", {16'd0, dac_sample}, {16'd0, e.sample});
                checkOutput("pulse_src", {31'd0, dac_src}, {31'd0, e.src});
                checkOutput("pulse_underrun", {31'd0, underrun}, {31'd0, e.under});
                checkOutput("pulse_a_ready", {31'd0, a_ready}, {31'd0, e.ar});
                checkOutput("pulse_b_ready", {31'd0, b_ready}, {31'd0, e.br});
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk_25mhz);
    endtask

    task automatic model_reset();
        m_a_full = 1'b0; m_b_full = 1'b0; m_ptr = 1'b0; m_src = 1'b0; m_under = 1'b0;
        m_a = 16'h0; m_b = 16'h0; m_last = 16'h8000;
        sb.delete();
    endtask

    task automatic check_reset_values();
        checkOutput("rst_data_ready", {31'd0, dac_data_ready}, 32'd0);
        checkOutput("rst_sample", {16'd0, dac_sample}, 32'h8000);
        checkOutput("rst_src", {31'd0, dac_src}, 32'd0);
        checkOutput("rst_underrun", {31'd0, underrun}, 32'd0);
        checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("rst_a_ready", {31'd0, a_ready}, 32'd0);
        checkOutput("rst_b_ready", {31'd0, b_ready}, 32'd0);
    endtask

    // Reset is raised away from any clock edge and sampled before the next one.
    task automatic do_reset();
        @(negedge clk_25mhz);
        #5 reset = 1'b1;
        enable = 1'b0; a_valid = 1'b0; b_valid = 1'b0; clear_flags = 1'b0;
        #1 check_reset_values();
        repeat (3) @(negedge clk_25mhz);
        reset = 1'b0;
        model_reset();
        @(negedge clk_25mhz);
        checkOutput("ready_a_after_reset", {31'd0, a_ready}, 32'd1);
        checkOutput("ready_b_after_reset", {31'd0, b_ready}, 32'd1);
    endtask

    task automatic start_enable();
        @(negedge clk_25mhz);
        enable = 1'b1;
        en_cyc = cyc;
        tick_k = 0;
        m_ptr  = 1'b0;
    endtask

    task automatic clear_and_check();
        @(negedge clk_25mhz);
        clear_flags = 1'b1;
        @(negedge clk_25mhz);
        clear_flags = 1'b0;
        m_under = 1'b0;
        checkOutput("underrun_cleared", {31'd0, underrun}, 32'd0);
        checkOutput("overrun_cleared", {31'd0, overrun}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic pa, input logic [15:0] va,
                                 input logic pb, input logic [15:0] vb, input logic late_a,
                                 input logic clr);
        exp_t e;
        int pulse_at;
        logic sel, pre_a_empty;
        pulse_at = en_cyc + (tick_k + 1) * DIV;
        wait_cyc(pulse_at - DIV + 10);
        mode = m;
        if (pa && !m_a_full) begin
            a_valid = 1'b1; a_data = va;
            @(negedge clk_25mhz);
            a_valid = 1'b0;
            m_a_full = 1'b1; m_a = va;
        end
        if (pb && !m_b_full) begin
            b_valid = 1'b1; b_data = vb;
            @(negedge clk_25mhz);
            b_valid = 1'b0;
            m_b_full = 1'b1; m_b = vb;
        end
        if (clr) begin
            clear_flags = 1'b1;
            @(negedge clk_25mhz);
            clear_flags = 1'b0;
            m_under = 1'b0;
        end
        pre_a_empty = !m_a_full;
        if (m == 2'd3) begin
            e.sample = 16'h8000;
            m_a_full = 1'b0; m_b_full = 1'b0;
        end else begin
            sel = (m == 2'd0) ? 1'b0 : (m == 2'd1) ? 1'b1 : m_ptr;
            if (m == 2'd2) m_ptr = ~m_ptr;
            if (sel ? m_b_full : m_a_full) begin
                e.sample = sel ? m_b : m_a;
                if (sel) m_b_full = 1'b0; else m_a_full = 1'b0;
                m_last = e.sample;
            end else begin
                e.sample = m_last;
                m_under = 1'b1;
            end
            m_src = sel;
        end
        if (late_a && pre_a_empty) begin
            wait_cyc(pulse_at - 1);
            a_valid = 1'b1; a_data = va ^ 16'hFFFF;
            @(negedge clk_25mhz);
            a_valid = 1'b0;
            m_a_full = 1'b1; m_a = va ^ 16'hFFFF;
        end
        e.src = m_src; e.under = m_under;
        e.ar = !m_a_full; e.br = !m_b_full; e.at = pulse_at;
        sb.push_back(e);
        tick_k++;
        last_pulse = pulse_at;
        wait_cyc(pulse_at + 1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk_25mhz);

        // Mode A, two pushes, pulses DIV apart.
        do_reset();
        start_enable();
        applyStimulus(2'd0, 1'b1, 16'h1234, 1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(2'd0, 1'b1, 16'h5678, 1'b0, 16'h0, 1'b0, 1'b0);

        // Alternate A/B.
        do_reset();
        start_enable();
        for (int i = 0; i < 3; i++)
            applyStimulus(2'd2, 1'b1, 16'hAAAA, 1'b1, 16'hBBBB, 1'b0, 1'b0);

        // Underrun on B, then refill and clear.
        do_reset();
        start_enable();
        applyStimulus(2'd1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(2'd1, 1'b0, 16'h0, 1'b1, 16'hC000, 1'b0, 1'b0);
        clear_and_check();

        // Mute with both slots full.
        do_reset();
        start_enable();
        applyStimulus(2'd3, 1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0, 1'b0);

        // Sample arriving on the tick edge is held for the next tick.
        do_reset();
        start_enable();
        applyStimulus(2'd0, 1'b0, 16'h3C3C, 1'b0, 16'h0, 1'b1, 1'b0);
        applyStimulus(2'd0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);

        // Tick forced inside GUARD must be dropped and flagged.
        wait_cyc(last_pulse + 20);
        checkOutput("overrun_idle", {31'd0, overrun}, 32'd0);
        force dut.tick_count = CW'(DIV - 1);
        @(negedge clk_25mhz);
        release dut.tick_count;
        @(negedge clk_25mhz);
        checkOutput("overrun_set", {31'd0, overrun}, 32'd1);
        repeat (60) @(negedge clk_25mhz);
        clear_and_check();

        // Reset 50 cycles into GUARD, then restart timing from enable.
        do_reset();
        start_enable();
        applyStimulus(2'd0, 1'b1, 16'h4321, 1'b0, 16'h0, 1'b0, 1'b0);
        wait_cyc(last_pulse + 51);
        #5 reset = 1'b1;
        enable = 1'b0;
        #1 check_reset_values();
        repeat (3) @(negedge clk_25mhz);
        reset = 1'b0;
        model_reset();
        start_enable();
        applyStimulus(2'd0, 1'b1, 16'h0F0F, 1'b0, 16'h0, 1'b0, 1'b0);

        // Randomized traffic across all modes.
        do_reset();
        start_enable();
        for (int i = 0; i < 25; i++) begin
            logic [1:0] rm;
            rm = 2'($urandom_range(3, 0));
            applyStimulus(rm, $urandom_range(2, 0) != 0, 16'($urandom),
                          $urandom_range(2, 0) != 0, 16'($urandom),
                          $urandom_range(4, 0) == 0, $urandom_range(5, 0) == 0);
        end

        repeat (20) @(negedge clk_25mhz);
        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
